// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_t : receiver FSM state encoding
//   PAR_EVEN / PAR_ODD : values of the parity-type select
//   DATA_BITS, START_BIT, STOP_BIT : serial frame constants
//   parity_bit() : parity bit expected for a byte and parity type
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   function automatic logic parity_bit(input logic [7:0] data, input logic typ);
      if (typ == PAR_ODD)
         return ~^data;
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling timer and 3-sample majority vote.
//   CLK, RST  : clock, synchronous active-low reset
//   rx_s      : synchronized serial line
//   start     : start edge seen in IDLE; this cycle is edge_cnt = 0
//   run       : frame in progress (FSM not idle)
//   bit_val   : majority of the three samples, valid while bit_rdy
//   bit_rdy   : resolve cycle (edge_cnt = OS/2+1)
//   bit_end   : last cycle of the bit (edge_cnt = OS-1)
module uart_rx_sampler #(
   parameter int OVERSAMPLE = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic rx_s,
   input  logic start,
   input  logic run,
   output logic bit_val,
   output logic bit_rdy,
   output logic bit_end
);

   localparam int             CW    = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]  SMP_A = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0]  SMP_B = CW'(OVERSAMPLE/2);
   localparam logic [CW-1:0]  SMP_C = CW'(OVERSAMPLE/2 + 1);
   localparam logic [CW-1:0]  LAST  = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] edge_cnt;
   logic          smp_a;
   logic          smp_b;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         edge_cnt <= '0;
         smp_a    <= 1'b0;
         smp_b    <= 1'b0;
      end else begin
         // the detect cycle itself is edge_cnt = 0, so the counter resumes at 1
         if (start)
            edge_cnt <= CW'(1);
         else if (run)
            edge_cnt <= (edge_cnt == LAST) ? '0 : edge_cnt + 1'b1;
         else
            edge_cnt <= '0;
         if (run && edge_cnt == SMP_A)
            smp_a <= rx_s;
         if (run && edge_cnt == SMP_B)
            smp_b <= rx_s;
      end
   end

   // third sample is the live line value in the resolve cycle
   assign bit_val = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
   assign bit_rdy = run && (edge_cnt == SMP_C);
   assign bit_end = run && (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits MSB first, optional parity.
//   CLK, RST    : clock, synchronous active-low reset
//   RX_IN       : asynchronous serial line, idles high
//   PAR_EN      : parity bit present (latched at start detect)
//   PAR_TYP     : 0 even, 1 odd (latched at start detect)
//   P_DATA      : last correctly received byte
//   DATA_VALID  : one-cycle pulse, P_DATA updated
//   PAR_ERR     : one-cycle pulse, parity mismatch
//   STP_ERR     : one-cycle pulse, stop bit sampled 0
//   Busy        : frame in progress
//
// state     | meaning
// ST_IDLE   | line idle, waiting for rx_s low
// ST_START  | start bit; resolved 1 means glitch, back to idle
// ST_DATA   | shifting 8 data bits, MSB first
// ST_PARITY | parity bit, mismatch recorded
// ST_STOP   | stop bit; frame closes at its resolve cycle
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic [7:0] P_DATA,
   output logic       DATA_VALID,
   output logic       PAR_ERR,
   output logic       STP_ERR,
   output logic       Busy
);

   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   rx_state_t  state;
   logic       rx_m;
   logic       rx_s;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       par_en_l;
   logic       par_typ_l;
   logic       par_bad;
   logic       start;
   logic       run;
   logic       bit_val;
   logic       bit_rdy;
   logic       bit_end;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RX_IN;
         rx_s <= rx_m;
      end
   end

   assign start = (state == ST_IDLE) && !rx_s;
   assign run   = (state != ST_IDLE);

   uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
      .CLK     (CLK),
      .RST     (RST),
      .rx_s    (rx_s),
      .start   (start),
      .run     (run),
      .bit_val (bit_val),
      .bit_rdy (bit_rdy),
      .bit_end (bit_end)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par_en_l   <= 1'b0;
         par_typ_l  <= 1'b0;
         par_bad    <= 1'b0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state     <= ST_START;
                  Busy      <= 1'b1;
                  par_en_l  <= PAR_EN;
                  par_typ_l <= PAR_TYP;
                  par_bad   <= 1'b0;
                  bit_cnt   <= '0;
               end
            end
            ST_START: begin
               if (bit_rdy && bit_val != START_BIT) begin
                  state <= ST_IDLE;
                  Busy  <= 1'b0;
               end else if (bit_end) begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_rdy)
                  shift <= {shift[6:0], bit_val};
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= par_en_l ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_rdy)
                  par_bad <= (bit_val != parity_bit(shift, par_typ_l));
               if (bit_end)
                  state <= ST_STOP;
            end
            ST_STOP: begin
               // close at the resolve cycle so the tail of the stop bit is
               // already idle and a back-to-back start is not missed
               if (bit_rdy) begin
                  state   <= ST_IDLE;
                  Busy    <= 1'b0;
                  PAR_ERR <= par_bad;
                  STP_ERR <= (bit_val != STOP_BIT);
                  if (bit_val == STOP_BIT && !par_bad) begin
                     P_DATA     <= shift;
                     DATA_VALID <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int OS = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
   logic       Busy;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       pe;
      logic       se;
      int         t;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive_bit(input logic b);
      RX_IN = b;
      repeat (OS) @(negedge CLK);
   endtask

   // Sends one frame; expected close edge = k + 79 (+8 with parity), k being
   // the first rising edge that samples the start bit.
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic stp,
                             input logic ev, input logic [7:0] ed,
                             input logic eperr, input logic eserr);
      exp_t e;
      logic [7:0] dd;
      dd      = d;
      PAR_EN  = pe;
      PAR_TYP = pt;
      e.v = ev; e.d = ed; e.pe = eperr; e.se = eserr;
      e.t = cyc + 1 + 79 + (pe ? 8 : 0);
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 7; i >= 0; i--) drive_bit(dd[i]);
      if (pe) drive_bit(pbit);
      drive_bit(stp);
      RX_IN = 1'b1;
   endtask

   initial begin
      // reset with the line toggling
      for (int i = 0; i < 5; i++) begin
         RX_IN = i[0];
         @(negedge CLK);
         check("reset_outputs", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy}, 0);
      end
      RX_IN = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      idle(4);

      fork
         forever begin
            @(negedge CLK);
            if (DATA_VALID || PAR_ERR || STP_ERR) begin
               if (q.size() == 0) begin
                  check("unexpected_pulse", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("data_valid", DATA_VALID, e.v);
                  check("par_err", PAR_ERR, e.pe);
                  check("stp_err", STP_ERR, e.se);
                  check("p_data", P_DATA, e.d);
                  check("busy_at_close", Busy, 0);
                  check("close_cycle", cyc, e.t);
               end
            end
         end
      join_none

      //          data   pe    pt    pbit  stop  valid data   perr  serr
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      idle(12);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      idle(12);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
      idle(12);
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
      idle(12);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
      idle(16);
      send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
      idle(12);

      // start glitch: two low cycles
      RX_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      begin
         int n;
         n = 0;
         while (!Busy && n < 10) begin @(negedge CLK); n++; end
         check("glitch_busy_rise", Busy, 1);
         n = 0;
         while (Busy && n < 20) begin @(negedge CLK); n++; end
         check("glitch_busy_fall", Busy, 0);
      end
      idle(12);
      check("glitch_p_data_held", P_DATA, 8'h66);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
      idle(12);

      // back to back, odd parity, stop bits exactly OS long
      send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

      // reset in the middle of data bit 4 of the next frame
      PAR_EN = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      RX_IN = 1'b0;
      repeat (OS/2) @(negedge CLK);
      check("busy_before_reset", Busy, 1);
      RST = 1'b0;
      RX_IN = 1'b1;
      repeat (2) @(negedge CLK);
      check("midframe_reset_outputs", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy}, 0);
      RST = 1'b1;
      idle(100);
      check("after_reset_busy", Busy, 0);
      check("after_reset_p_data", P_DATA, 0);
      check("leftover_expectations", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the downstream counterpart of `UART_TX`, consuming its serial frame format. Frame format:

- one start bit (0);
- 8 data bits, MSB first;
- an optional parity bit (even or odd);
- one stop bit (1).

Each bit is oversampled by `OVERSAMPLE` clocks and resolved by a 3-sample majority vote. A checked byte is delivered as a one-cycle `DATA_VALID` pulse, with per-frame parity and stop error flags.

## Interface

- `OVERSAMPLE`, default 8: clocks per serial bit. Must be even and ≥ 6.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-low reset.
- `RX_IN` in 1: serial line, asynchronous to `CLK`, idles high.
- `PAR_EN` in 1: 1 = parity bit present in frame.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `P_DATA` out 8: last correctly received byte.
- `DATA_VALID` out 1: one-cycle pulse, `P_DATA` is new.
- `PAR_ERR` out 1: one-cycle pulse, parity mismatch.
- `STP_ERR` out 1: one-cycle pulse, stop bit sampled 0.
- `Busy` out 1: high from start detect to frame end.

## Operation

**Input synchronizer**
- `RX_IN` passes through a 2-FF synchronizer; the result is `rx_s`.
- Both flops reset to 1.

**Counters**
- `edge_cnt` counts 0..OS-1 within each bit, then wraps to 0 and increments `bit_cnt`.
- Samples are taken at `edge_cnt` = OS/2-1, OS/2, OS/2+1.
- The bit value is the majority of the three samples, resolved in the cycle `edge_cnt` = OS/2+1.

**FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `rx_s` = 0 → START, with that cycle counted as `edge_cnt` = 0. `PAR_EN`/`PAR_TYP` are latched in this cycle; changes mid-frame are ignored.
- **START:**
  - Resolved bit = 1 → glitch: back to IDLE, no output, no flags.
  - Otherwise continue to end of bit → DATA.
- **DATA:**
  - 8 bits are shifted in, MSB first; the first data bit lands in bit 7.
  - After bit 8 → PARITY if latched `PAR_EN`, else STOP.
- **PARITY:** expected bit = `^data` for even, `~^data` for odd. A mismatch is recorded.
- **STOP:** at the stop-bit resolve cycle, the frame closes and the FSM goes → IDLE immediately. The rest of the stop bit is then idle-high, so a back-to-back frame is detected.

**Frame close** (outputs registered, visible the next cycle):
- Stop = 1 and no parity mismatch:
  - `P_DATA` ← byte.
  - `DATA_VALID` = 1.
- Parity mismatch: `PAR_ERR` = 1.
- Stop = 0: `STP_ERR` = 1.
- Both errors may pulse together.
- On any error, `DATA_VALID` = 0 and `P_DATA` holds its previous value.

**Busy:** high in START/DATA/PARITY/STOP.

**Reset (`RST` low at a rising edge, any state, including mid-frame):**
- FSM → IDLE; counters and shift register → 0; synchronizer → 1.
- `P_DATA` = 0x00; `DATA_VALID`, `PAR_ERR`, `STP_ERR`, `Busy` = 0.
- Any partial frame is discarded.

## Timing

- Let k = the first rising edge at which `RX_IN` is sampled low.
- `rx_s` is low at the FSM at edge k+2 (t0).
- The stop-bit resolve edge is t0 + (9+PAR_EN)·OS + OS/2 + 1.
- `DATA_VALID`/flags are high for exactly the one cycle after that edge.
- OS = 8: edge k+79 without parity, k+87 with parity.
- `Busy` rises after edge k+2 and falls in the same cycle the flags appear.
- Minimum frame spacing: a new start bit may begin immediately after a stop bit of OS cycles.
- Throughput: one byte per (10+PAR_EN)·OS cycles.
- Spurious-low tolerance: a start bit shorter than OS/2-1 cycles is rejected as a glitch.
- Simultaneous events: reset has priority over everything. A falling `rx_s` in the frame-close cycle is not a start; detection starts the following cycle.

## Structure

- Shared `uart_pkg`:
  - FSM state encoding;
  - `PAR_EVEN` = 0, `PAR_ODD` = 1;
  - frame constants `DATA_BITS` = 8, `START_BIT` = 0, `STOP_BIT` = 1.
  - `UART_TX` reuses the parity and frame constants.
- One sub-module, `uart_rx_sampler`:
  - owns `edge_cnt`, the three sample registers and the majority vote;
  - outputs `bit_val`, `bit_rdy` (resolve cycle) and `bit_end` (`edge_cnt` = OS-1).
- The FSM, bit counter, shift register and parity check stay in `uart_rx`.

## Test plan

- **Reset:** hold `RST` = 0 for 5 cycles with `RX_IN` toggling → all outputs 0, `P_DATA` = 0x00, no pulses.
- **No-parity frame:** OS = 8, frame 0xA5 with `PAR_EN` = 0 → `DATA_VALID` one cycle after edge k+79, `P_DATA` = 0xA5, no error flags.
- **Parity frames:**
  - 0x3C, even parity, parity bit 0 → valid, `P_DATA` = 0x3C.
  - Same frame with parity bit 1 → `PAR_ERR` one cycle, `DATA_VALID` = 0, `P_DATA` stays 0x3C.
  - 0x01 odd parity, parity bit 0 → valid.
- **Stop error:** 0x55 with stop bit 0 → `STP_ERR` pulse, no `DATA_VALID`. Then `RX_IN` is released high and frame 0x66 follows → valid 0x66.
- **Start glitch:** `RX_IN` low for 2 cycles then high → `Busy` pulses, no flags, back to IDLE. A following frame 0x81 is received correctly.
- **Back-to-back and mid-frame reset:**
  - 0x00 then 0xFF (odd parity), stop bits exactly OS cycles → two `DATA_VALID` pulses, 88 cycles apart.
  - `RST` asserted during bit 4 of the next frame → no output, clean IDLE.
